keypad_hex_entry: RTL and testbench

//  Input-side companion to the 8-digit seven-segment display path: scans a 4x4 hex keypad.

---
 rtl/keypad_hex_entry_pkg.sv | 23 ++
 rtl/keypad_hex_entry_tick_divider.sv | 19 +
 rtl/keypad_hex_entry.sv | 107 ++++++++++
 tb/tb_keypad_hex_entry.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/keypad_hex_entry_pkg.sv
// keypad_hex_entry_pkg: shared FSM encoding, keypad map and scan helpers
//   state_t     SCAN / DEBOUNCE / PRESSED / RELEASE
//   COL_RESET   column strobe after reset (col0 driven low)
//   ROW_IDLE    row value with no key pressed
//   KEYMAP      key value indexed by {row, col}
package keypad_hex_entry_pkg;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] ROW_IDLE = 4'hF;
    localparam logic [0:15][3:0] KEYMAP = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };
    function automatic logic [3:0] rotate_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction
    // Index of the lowest active-low bit; used for both the row hit and the strobed column
    function automatic logic [1:0] low_index(input logic [3:0] v);
        return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
    endfunction
endpackage

// File: rtl/keypad_hex_entry_tick_divider.sv
// keypad_hex_entry_tick_divider: free-running divider giving a 1-clock tick every DIV clocks
//   clock  in   system clock
//   reset  in   asynchronous active-high reset
//   tick   out  high for the one clock in which the counter wraps
module keypad_hex_entry_tick_divider #(
    parameter int DIV = 100000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] count;
    assign tick = count == W'(DIV - 1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) count <= '0;
        else count <= tick ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: 4x4 hex keypad scanner with debounce, shifting keys into a 32-bit word
//   clock         in   system clock
//   reset         in   asynchronous active-high reset
//   row[3:0]      in   keypad rows, active-low, asynchronous
//   col[3:0]      out  column strobes, active-low, one low at a time
//   clear         in   synchronous clear of data and digit_count
//   data[31:0]    out  entered word, newest key in data[3:0]
//   nibble[3:0]   out  last accepted key
//   nibble_valid  out  1-clock pulse per accepted key
//   digit_count   out  keys entered since reset/clear, saturating at 8
module keypad_hex_entry
    import keypad_hex_entry_pkg::*;
#(
    parameter int CLK_DIV        = 100000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        clear,
    output logic [31:0] data,
    output logic [3:0]  nibble,
    output logic        nibble_valid,
    output logic [3:0]  digit_count
);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    // Count value at which the next stable tick completes the debounce window
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
    logic          tick;
    logic [3:0]    row_meta;
    logic [3:0]    rs;
    logic [3:0]    cap;
    logic [1:0]    key_r;
    logic [1:0]    key_c;
    logic [CW-1:0] cnt;
    state_t        state;
    keypad_hex_entry_tick_divider #(.DIV(CLK_DIV)) u_tick (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );
    // col only moves on a tick, so every tick sees rows that have settled for a full tick
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_meta     <= ROW_IDLE;
            rs           <= ROW_IDLE;
            state        <= SCAN;
            col          <= COL_RESET;
            cnt          <= '0;
            cap          <= ROW_IDLE;
            key_r        <= '0;
            key_c        <= '0;
            nibble       <= '0;
            nibble_valid <= 1'b0;
            data         <= '0;
            digit_count  <= '0;
        end else begin
            row_meta     <= row;
            rs           <= row_meta;
            nibble_valid <= 1'b0;
            case (state)
                SCAN: if (tick) begin
                    if (rs == ROW_IDLE) col <= rotate_col(col);
                    else begin
                        cap   <= rs;
                        key_r <= low_index(rs);
                        key_c <= low_index(col);
                        cnt   <= CW'(1);
                        state <= DEBOUNCE_TICKS > 1 ? DEBOUNCE : PRESSED;
                    end
                end
                DEBOUNCE: if (tick) begin
                    if (rs == cap) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= PRESSED;
                    end else begin
                        cnt   <= '0;
                        col   <= rotate_col(col);
                        state <= SCAN;
                    end
                end
                PRESSED: begin
                    nibble       <= KEYMAP[{key_r, key_c}];
                    nibble_valid <= 1'b1;
                    data         <= {data[27:0], KEYMAP[{key_r, key_c}]};
                    digit_count  <= digit_count + {3'b0, digit_count != 4'd8};
                    cnt          <= '0;
                    state        <= RELEASE;
                end
                RELEASE: if (tick) begin
                    if (rs != ROW_IDLE) cnt <= '0;
                    else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        col   <= rotate_col(col);
                        state <= SCAN;
                    end else cnt <= cnt + 1'b1;
                end
            endcase
            // Later assignment takes priority over a same-clock PRESSED update
            if (clear) begin
                data        <= '0;
                digit_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_keypad_hex_entry.sv
// tb_keypad_hex_entry: directed self-checking bench for keypad_hex_entry (CLK_DIV=4, DEBOUNCE_TICKS=3)
module tb_keypad_hex_entry;
    import keypad_hex_entry_pkg::*;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        clear = 1'b0;
    logic [31:0] data;
    logic [3:0]  nibble;
    logic        nibble_valid;
    logic [3:0]  digit_count;
    logic [15:0] keys = '0;
    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    keypad_hex_entry #(.CLK_DIV(4), .DEBOUNCE_TICKS(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .row         (row),
        .col         (col),
        .clear       (clear),
        .data        (data),
        .nibble      (nibble),
        .nibble_valid(nibble_valid),
        .digit_count (digit_count)
    );
    always #5 clock = ~clock;
    // Keypad model: a held key at (r,c) pulls row r low while column c is strobed
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
    end
    always @(negedge clock) if (nibble_valid) pulses <= pulses + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic wait_ticks(input int n);
        repeat (n * 4) @(negedge clock);
    endtask
    task automatic wait_accept(input string tag, input logic [3:0] exp);
        bit seen = 0;
        for (int j = 0; j < 120 && !seen; j++) begin
            @(negedge clock);
            seen = nibble_valid;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_nibble"}, 32'(nibble), 32'(exp));
    endtask
    task automatic check_col_steps(input string tag, input int n);
        logic [3:0] prev;
        bit seen;
        for (int k = 0; k < n; k++) begin
            prev = col;
            seen = 0;
            for (int j = 0; j < 8 && !seen; j++) begin
                @(negedge clock);
                seen = col != prev;
            end
            check(tag, {27'd0, seen, col}, {27'd0, 1'b1, prev[2:0], prev[3]});
        end
    endtask
    int key_idx [10] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 3};
    logic [3:0] key_val [10] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    initial begin
        int p0;
        bit seen;
        repeat (3) @(negedge clock);
        check("rst_col", 32'(col), 32'h0000000E);
        check("rst_data", data, 32'h0);
        check("rst_nibble", 32'(nibble), 32'h0);
        check("rst_valid", 32'(nibble_valid), 32'h0);
        check("rst_count", 32'(digit_count), 32'h0);
        reset = 1'b0;
        // 1: idle scanning rotates the strobe every tick
        check_col_steps("idle_col", 40);
        check("idle_pulses", 32'(pulses), 32'd0);
        check("idle_data", data, 32'h0);
        // 2: single held key r1c2
        p0 = pulses;
        keys[6] = 1'b1;
        wait_ticks(10);
        keys[6] = 1'b0;
        wait_ticks(8);
        check("hold_pulses", 32'(pulses - p0), 32'd1);
        check("hold_nibble", 32'(nibble), 32'h6);
        check("hold_data", data, 32'h00000006);
        check("hold_count", 32'(digit_count), 32'd1);
        // 3: bouncing r0c0 never accepted, scanning resumes
        p0 = pulses;
        for (int k = 0; k < 6; k++) begin
            keys[0] = ~keys[0];
            wait_ticks(1);
        end
        keys[0] = 1'b0;
        wait_ticks(8);
        check("bounce_pulses", 32'(pulses - p0), 32'd0);
        check_col_steps("bounce_col", 2);
        check("bounce_data", data, 32'h00000006);
        // clear alone
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clear_data", data, 32'h0);
        check("clear_count", 32'(digit_count), 32'd0);
        // 4: ten keys, oldest two shifted out, count saturates
        for (int k = 0; k < 10; k++) begin
            keys[key_idx[k]] = 1'b1;
            wait_accept("entry", key_val[k]);
            keys[key_idx[k]] = 1'b0;
            wait_ticks(6);
            if (k == 7) check("entry_count8", 32'(digit_count), 32'd8);
        end
        check("entry_data", data, 32'h3456789A);
        check("entry_count", 32'(digit_count), 32'd8);
        // 5: clear in the PRESSED clock wins over the shift
        keys[13] = 1'b1;
        seen = 0;
        for (int j = 0; j < 120 && !seen; j++) begin
            @(negedge clock);
            seen = dut.state == PRESSED;
        end
        check("clrpress_seen", 32'(seen), 32'd1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clrpress_valid", 32'(nibble_valid), 32'd1);
        check("clrpress_nibble", 32'(nibble), 32'hF);
        check("clrpress_data", data, 32'h0);
        check("clrpress_count", 32'(digit_count), 32'd0);
        keys[13] = 1'b0;
        wait_ticks(6);
        // 6: async reset while r2c3 is held in RELEASE
        keys[11] = 1'b1;
        wait_accept("pre_rst", 4'hC);
        check("pre_rst_data", data, 32'h0000000C);
        wait_ticks(2);
        #1 reset = 1'b1;
        #1;
        check("async_col", 32'(col), 32'h0000000E);
        check("async_data", data, 32'h0);
        check("async_nibble", 32'(nibble), 32'h0);
        check("async_valid", 32'(nibble_valid), 32'h0);
        check("async_count", 32'(digit_count), 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        p0 = pulses;
        wait_accept("post_rst", 4'hC);
        check("post_rst_data", data, 32'h0000000C);
        check("post_rst_count", 32'(digit_count), 32'd1);
        wait_ticks(6);
        check("post_rst_pulses", 32'(pulses - p0), 32'd1);
        keys[11] = 1'b0;
        wait_ticks(6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
